// File: rtl/cfg_pkt_pkg.sv
// Beat format shared by configuration-chain masters: tags, type codes, field offsets and beat builders.
package cfg_pkt_pkg;

  localparam int BEAT_W   = 134;
  localparam int TAG_LSB  = 132;
  localparam int TYPE_LSB = 124;
  localparam int SRC_LSB  = 104;
  localparam int DST_LSB  = 96;
  localparam int ADDR_LSB = 64;
  localparam int DATA_LSB = 0;

  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [2:0] TYPE_WR     = 3'b010;
  localparam logic [2:0] TYPE_RD     = 3'b001;
  localparam logic [3:0] TYPE_RD_RSP = 4'b1011;

  typedef logic [BEAT_W-1:0] beat_t;

  // Request type codes are 3 bits wide but occupy a 4-bit field with a zero MSB.
  function automatic beat_t build_header(input logic        rd,
                                         input logic [7:0]  src,
                                         input logic [7:0]  dst,
                                         input logic [31:0] addr,
                                         input logic [31:0] wdata);
    beat_t b;
    b = '0;
    b[TAG_LSB +: 2]   = TAG_HDR;
    b[TYPE_LSB +: 4]  = rd ? {1'b0, TYPE_RD} : {1'b0, TYPE_WR};
    b[SRC_LSB +: 8]   = src;
    b[DST_LSB +: 8]   = dst;
    b[ADDR_LSB +: 32] = addr;
    b[DATA_LSB +: 32] = rd ? 32'h0 : wdata;
    return b;
  endfunction

  function automatic beat_t build_tail();
    beat_t b;
    b = '0;
    b[TAG_LSB +: 2] = TAG_TAIL;
    return b;
  endfunction

endpackage

// File: rtl/cfg_pkt_master.sv
// Configuration packet master: turns one read/write command into a header+tail beat pair and waits for the read reply.
// Optional read-response timeout is compiled in with the CFG_TIMEOUT_EN macro.
module cfg_pkt_master
  import cfg_pkt_pkg::*;
#(
  parameter logic [7:0]  SRC_MID     = 8'd1,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [7:0]        cmd_dst_mid,
  input  logic [31:0]       cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [BEAT_W-1:0] cout_data,
  output logic              cout_data_wr,
  input  logic              cin_ready,
  input  logic [BEAT_W-1:0] cin_data,
  input  logic              cin_data_wr,
  output logic              cout_ready
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_TAIL     = 3'd2;
  localparam logic [2:0] ST_WAIT_RSP = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic [7:0]        cmd_dst_q, cmd_dst_d;
  logic [31:0]       cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic [BEAT_W-1:0] cout_data_q, cout_data_d;
  logic              cout_wr_q, cout_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef CFG_TIMEOUT_EN
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
`endif
  logic              reply_match;
  logic              unused_cin;

  // Only the fields that identify a read reply take part in the match; the reply's source MID is irrelevant.
  assign reply_match = (state_q == ST_WAIT_RSP) && cin_data_wr
                    && (cin_data[TAG_LSB +: 2]   == TAG_HDR)
                    && (cin_data[TYPE_LSB +: 4]  == TYPE_RD_RSP)
                    && (cin_data[DST_LSB +: 8]   == SRC_MID)
                    && (cin_data[ADDR_LSB +: 32] == cmd_addr_q);

  assign unused_cin = &{1'b0, cin_data[131:128], cin_data[123:104], cin_data[63:32], TIMEOUT_CYC};

  always_comb begin
    state_d     = state_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_dst_d   = cmd_dst_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cout_data_d = '0;
    cout_wr_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
`ifdef CFG_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_rd_d    = cmd_rd;
          cmd_dst_d   = cmd_dst_mid;
          cmd_addr_d  = cmd_addr;
          cmd_wdata_d = cmd_wdata;
          rdata_d     = '0;
`ifdef CFG_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (cin_ready) begin
          cout_data_d = build_header(cmd_rd_q, SRC_MID, cmd_dst_q, cmd_addr_q, cmd_wdata_q);
          cout_wr_d   = 1'b1;
          state_d     = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (cin_ready) begin
          cout_data_d = build_tail();
          cout_wr_d   = 1'b1;
          state_d     = cmd_rd_q ? ST_WAIT_RSP : ST_DONE;
`ifdef CFG_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_WAIT_RSP: begin
`ifdef CFG_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
        // A reply landing in the expiry cycle still wins over the timeout.
        if (reply_match) begin
          rdata_d = cin_data[DATA_LSB +: 32];
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
`else
        if (reply_match) begin
          rdata_d = cin_data[DATA_LSB +: 32];
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rdata_q;
`ifdef CFG_TIMEOUT_EN
        rsp_err_d   = err_q;
`endif
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_rd_q    <= 1'b0;
      cmd_dst_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
`ifdef CFG_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_dst_q   <= cmd_dst_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cout_data_q <= cout_data_d;
      cout_wr_q   <= cout_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
`ifdef CFG_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign cout_data    = cout_data_q;
  assign cout_data_wr = cout_wr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign cout_ready   = 1'b1;

endmodule

// File: tb/tb_cfg_pkt_master.sv
// Bench for cfg_pkt_master: directed and randomized transactions checked against a beat/response model.
module tb_cfg_pkt_master;

  localparam logic [7:0]  SRC = 8'h3C;
  localparam logic [15:0] TO  = 16'd48;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_rd;
  logic [7:0]   cmd_dst_mid;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_data;
  logic [133:0] cout_data, cin_data;
  logic         cout_data_wr, cin_ready, cin_data_wr, cout_ready;

  typedef struct { logic [133:0] d; int c; } beat_s;
  typedef struct { logic [31:0] d; logic e; int c; } rsp_s;

  beat_s beatQ[$];
  rsp_s  rspQ[$];
  int    cyc = 0;
  int    dirty = 0;
  int    total = 0;
  int    bad = 0;
  bit    randReady = 1'b0;

  cfg_pkt_master #(.SRC_MID(SRC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_dst_mid(cmd_dst_mid), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cout_data(cout_data), .cout_data_wr(cout_data_wr), .cin_ready(cin_ready),
    .cin_data(cin_data), .cin_data_wr(cin_data_wr), .cout_ready(cout_ready)
  );

  always #5 clk = ~clk;

  // Record every emitted beat and completion with the cycle it appeared in.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cout_data_wr) beatQ.push_back('{d: cout_data, c: cyc});
    else if (cout_data != '0) dirty++;
    if (rsp_valid) rspQ.push_back('{d: rsp_data, e: rsp_err, c: cyc});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [133:0] expHdr(logic rd, logic [7:0] dst, logic [31:0] addr, logic [31:0] wdata);
    return {2'b01, 4'h0, (rd ? 4'b0001 : 4'b0010), 12'h000, SRC, dst, addr, 32'h0, (rd ? 32'h0 : wdata)};
  endfunction

  function automatic logic [133:0] expTail();
    return {2'b10, 132'h0};
  endfunction

  function automatic logic [133:0] mkReply(logic [7:0] src, logic [7:0] dst, logic [31:0] addr,
                                           logic [31:0] data, logic [3:0] typ);
    return {2'b01, 4'h0, typ, 12'h000, src, dst, addr, 32'h0, data};
  endfunction

  task automatic checkOutput(string tag, logic [133:0] obs, logic [133:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (randReady) cin_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(logic rd, logic [7:0] dst, logic [31:0] addr, logic [31:0] wdata);
    int budget = 50;
    cmd_valid = 1'b1;
    cmd_rd = rd;
    cmd_dst_mid = dst;
    cmd_addr = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_rd = $urandom_range(0, 1);
    cmd_addr = $urandom();
    cmd_wdata = $urandom();
  endtask

  task automatic waitBeats(int n);
    int budget = 200;
    while (beatQ.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("beat_wait", beatQ.size(), n);
  endtask

  task automatic waitRsp(int budget);
    while (rspQ.size() == 0 && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("rsp_wait", rspQ.size(), 1);
  endtask

  task automatic sendBeat(logic [133:0] b);
    cin_data = b;
    cin_data_wr = 1'b1;
    tick();
    cin_data_wr = 1'b0;
  endtask

  task automatic checkTxn(string tag, logic rd, logic [7:0] dst, logic [31:0] addr, logic [31:0] wdata,
                          logic [31:0] expData, logic expErr);
    logic [133:0] h = 'x;
    logic [133:0] t = 'x;
    logic [31:0]  d = 'x;
    logic         e = 1'bx;
    if (beatQ.size() > 0) h = beatQ[0].d;
    if (beatQ.size() > 1) t = beatQ[1].d;
    if (rspQ.size() > 0) begin
      d = rspQ[0].d;
      e = rspQ[0].e;
    end
    checkOutput({tag, "_nbeats"}, beatQ.size(), 2);
    checkOutput({tag, "_hdr"}, h, expHdr(rd, dst, addr, wdata));
    checkOutput({tag, "_tail"}, t, expTail());
    checkOutput({tag, "_nrsp"}, rspQ.size(), 1);
    checkOutput({tag, "_rdata"}, d, expData);
    checkOutput({tag, "_err"}, e, expErr);
    beatQ.delete();
    rspQ.delete();
  endtask

  initial begin : stim
    logic        rd;
    logic [7:0]  dst;
    logic [31:0] addr, wdata, rdata, lastAddr;
    logic [133:0] b;
    int          tailC, lat, junk;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_dst_mid = '0; cmd_addr = '0; cmd_wdata = '0;
    cin_ready = 1'b1; cin_data = '0; cin_data_wr = 1'b0;
    repeat (3) tick();
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_cout_wr", cout_data_wr, 0);
    checkOutput("rst_cout_data", cout_data, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("cout_ready", cout_ready, 1);
    rst = 1'b0;
    tick();

    $display("[TB] write with free-flowing chain");
    applyStimulus(1'b0, 8'd7, 32'h7000_0000, 32'h11);
    waitRsp(50);
    if (beatQ.size() == 2 && rspQ.size() == 1) begin
      checkOutput("wr_tail_gap", beatQ[1].c - beatQ[0].c, 1);
      checkOutput("wr_rsp_gap", rspQ[0].c - beatQ[1].c, 1);
    end
    checkTxn("wr", 1'b0, 8'd7, 32'h7000_0000, 32'h11, 32'h0, 1'b0);

    $display("[TB] read with matching reply");
    applyStimulus(1'b1, 8'd9, 32'h7000_000A, 32'hDEAD);
    waitBeats(2);
    repeat (2) tick();
    sendBeat(mkReply(8'd9, SRC, 32'h7000_000A, 32'h5, 4'b1011));
    waitRsp(20);
    checkTxn("rd", 1'b1, 8'd9, 32'h7000_000A, 32'hDEAD, 32'h5, 1'b0);

    $display("[TB] write with chain stalled for three cycles");
    cin_ready = 1'b0;
    applyStimulus(1'b0, 8'd3, 32'h0000_1234, 32'hCAFE);
    repeat (3) tick();
    checkOutput("stall_no_beat", beatQ.size(), 0);
    cin_ready = 1'b1;
    waitRsp(20);
    checkTxn("stall", 1'b0, 8'd3, 32'h0000_1234, 32'hCAFE, 32'h0, 1'b0);

    $display("[TB] read with non-matching replies");
    applyStimulus(1'b1, 8'd5, 32'h7000_000A, 32'h0);
    waitBeats(2);
    tailC = (beatQ.size() >= 2) ? beatQ[1].c : cyc;
    sendBeat(mkReply(8'd5, SRC, 32'h7000_000B, 32'h99, 4'b1011));
    sendBeat(mkReply(8'd5, SRC ^ 8'h01, 32'h7000_000A, 32'h98, 4'b1011));
    b = mkReply(8'd5, SRC, 32'h7000_000A, 32'h97, 4'b1011);
    b[133:132] = 2'b10;
    sendBeat(b);
`ifdef CFG_TIMEOUT_EN
    waitRsp(int'(TO) + 20);
    if (rspQ.size() == 1) checkOutput("timeout_gap", rspQ[0].c - tailC, int'(TO) + 1);
    checkTxn("timeout", 1'b1, 8'd5, 32'h7000_000A, 32'h0, 32'h0, 1'b1);
    sendBeat(mkReply(8'd5, SRC, 32'h7000_000A, 32'h77, 4'b1011));
    repeat (5) tick();
    checkOutput("late_reply_ignored", rspQ.size(), 0);
    checkOutput("late_reply_idle", cmd_ready, 1);
`else
    repeat (int'(TO) + 10) tick();
    checkOutput("mismatch_ignored", rspQ.size(), 0);
    sendBeat(mkReply(8'd5, SRC, 32'h7000_000A, 32'h77, 4'b1011));
    waitRsp(20);
    checkTxn("mismatch", 1'b1, 8'd5, 32'h7000_000A, 32'h0, 32'h77, 1'b0);
`endif

    $display("[TB] reply in the timeout-expiry cycle");
    applyStimulus(1'b1, 8'd6, 32'h0000_0040, 32'h0);
    waitBeats(2);
    tailC = (beatQ.size() >= 2) ? beatQ[1].c : cyc;
    while (cyc < tailC + int'(TO) - 1) tick();
    sendBeat(mkReply(8'd6, SRC, 32'h0000_0040, 32'hABCD, 4'b1011));
    waitRsp(10);
    checkTxn("coincide", 1'b1, 8'd6, 32'h0000_0040, 32'h0, 32'hABCD, 1'b0);

    $display("[TB] reset between header and tail");
    applyStimulus(1'b1, 8'd2, 32'h0000_0055, 32'h0);
    waitBeats(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_cout_wr", cout_data_wr, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    tick();
    checkOutput("midrst_cmd_ready", cmd_ready, 1);
    repeat (10) tick();
    checkOutput("midrst_no_tail", beatQ.size(), 1);
    checkOutput("midrst_no_rsp", rspQ.size(), 0);
    beatQ.delete();
    rspQ.delete();

    $display("[TB] randomized transactions");
    lastAddr = 32'h0000_0055;
    for (int i = 0; i < 24; i++) begin
      rd = $urandom_range(0, 1);
      dst = $urandom();
      addr = $urandom();
      wdata = $urandom();
      rdata = $urandom();
      lat = $urandom_range(0, 20);
      junk = $urandom_range(0, 4);
      randReady = 1'b1;
      if ($urandom_range(0, 3) == 0) sendBeat(mkReply(8'h11, SRC, lastAddr, $urandom(), 4'b1011));
      applyStimulus(rd, dst, addr, wdata);
      waitBeats(2);
      if (rd) begin
        b = mkReply(dst, SRC, addr, 32'hBAD0_0000 | i, 4'b1011);
        case (junk)
          1: b[95:64] = addr ^ 32'h1;
          2: b[103:96] = SRC ^ 8'h80;
          3: b[127:124] = 4'b0001;
          4: b[133:132] = 2'b10;
          default: ;
        endcase
        if (junk != 0) sendBeat(b);
        repeat (lat) tick();
        sendBeat(mkReply(dst, SRC, addr, rdata, 4'b1011));
      end
      waitRsp(40);
      randReady = 1'b0;
      cin_ready = 1'b1;
      checkTxn("rand", rd, dst, addr, wdata, rd ? rdata : 32'h0, 1'b0);
      lastAddr = addr;
    end

    checkOutput("idle_beats_zero", dirty, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
